// File: rtl/rv_pkg.sv
// Shared register-file constants and the write-back entry payload.
package rv_pkg;

   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned XLEN       = 32;

   localparam logic [REG_ADDR_W-1:0] REG_ZERO = REG_ADDR_W'(0);

   // One buffered mul/div result: destination plus data.
   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } wb_entry_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Mul/div result handshake channel into the write-back arbiter.
//   md_valid/md_rd/md_data : result offered by the mul/div unit
//   md_ready               : arbiter can accept a result this cycle
interface regfile_wb_arbiter_if;
   import rv_pkg::*;

   logic                  md_valid;
   logic [REG_ADDR_W-1:0] md_rd;
   logic [XLEN-1:0]       md_data;
   logic                  md_ready;

   modport master (output md_valid, output md_rd, output md_data, input md_ready);
   modport slave  (input md_valid, input md_rd, input md_data, output md_ready);

endinterface

// File: rtl/regfile_wb_arbiter_fifo.sv
// wb_fifo: DEPTH-entry synchronous FIFO of write-back entries.
//   push/din  : enqueue (ignored when full)
//   pop       : dequeue (ignored when empty)
//   head_c    : current head entry (combinational read)
//   count     : registered occupancy; full/empty registered alongside it
module wb_fifo
   import rv_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    push,
   input  wb_entry_t               din,
   input  logic                    pop,
   output wb_entry_t               head_c,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    full,
   output logic                    empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   wb_entry_t         mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              push_ok;
   logic              pop_ok;
   logic [CW-1:0]     count_nxt;

   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign head_c  = mem[rd_ptr];

   // Occupancy after this cycle's push/pop.
   always_comb begin
      count_nxt = count;
      if (push_ok && !pop_ok)      count_nxt = count + CW'(1);
      else if (!push_ok && pop_ok) count_nxt = count - CW'(1);
   end

   // Storage array carries no reset; validity is tracked by count.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         count <= count_nxt;
         full  <= (count_nxt == CW'(DEPTH));
         empty <= (count_nxt == '0);
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: merges ALU results with buffered mul/div
// results, tracks pending mul/div destinations, flags RAW hazards and forces a
// drain slot (wb_stall) when the FIFO head has waited too long.
//   alu_*           : single-cycle result (has priority)
//   md_issue_*      : mul/div issue, sets the pending bit
//   md (slave)      : mul/div result handshake
//   rs1/rs2, hazard : decode-stage hazard query
//   issue_conflict  : issued destination already pending (combinational)
//   wb_stall        : core must not present alu_valid this cycle
//   reg_write/rd/wd : registered register-file write port
//   pending_mask    : scoreboard, bit 0 always 0
//   proto_err       : sticky, alu_valid seen during wb_stall
module regfile_wb_arbiter
   import rv_pkg::*;
#(
   parameter int unsigned DEPTH        = 2,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  alu_valid,
   input  logic [REG_ADDR_W-1:0] alu_rd,
   input  logic [XLEN-1:0]       alu_data,
   input  logic                  md_issue_valid,
   input  logic [REG_ADDR_W-1:0] md_issue_rd,
   regfile_wb_arbiter_if.slave   md,
   input  logic [REG_ADDR_W-1:0] rs1,
   input  logic [REG_ADDR_W-1:0] rs2,
   output logic                  hazard,
   output logic                  issue_conflict,
   output logic                  wb_stall,
   output logic                  reg_write,
   output logic [REG_ADDR_W-1:0] rd,
   output logic [XLEN-1:0]       wd,
   output logic [31:0]           pending_mask,
   output logic                  proto_err
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

   wb_entry_t     head;
   logic [CW-1:0] fifo_count;
   logic          fifo_full;
   logic          fifo_empty;
   logic          alu_sel;
   logic          pop;
   logic          push;
   logic          issue_set;
   logic          waiting;
   logic          starve_hit;
   logic [SW-1:0] starve_cnt;
   logic [SW-1:0] starve_inc;
   logic [31:0]   pending_nxt;

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .push   (push),
      .din    ('{rd: md.md_rd, data: md.md_data}),
      .pop    (pop),
      .head_c (head),
      .count  (fifo_count),
      .full   (fifo_full),
      .empty  (fifo_empty)
   );

   // Selection: a real ALU write wins; otherwise the FIFO head drains.
   assign alu_sel   = alu_valid && (alu_rd != REG_ZERO);
   assign pop       = !alu_sel && !fifo_empty;
   assign md.md_ready = (fifo_count < CW'(DEPTH));
   // rd==0 results are accepted by the handshake but never stored.
   assign push      = md.md_valid && !fifo_full && (md.md_rd != REG_ZERO);
   assign issue_set = md_issue_valid && (md_issue_rd != REG_ZERO);

   assign hazard = ((rs1 != REG_ZERO) && pending_mask[rs1]) ||
                   ((rs2 != REG_ZERO) && pending_mask[rs2]);
   assign issue_conflict = issue_set && pending_mask[md_issue_rd];

   // Pop clears first so a same-index issue in the same cycle wins.
   always_comb begin
      pending_nxt = pending_mask;
      if (pop)       pending_nxt[head.rd]     = 1'b0;
      if (issue_set) pending_nxt[md_issue_rd] = 1'b1;
      pending_nxt[0] = 1'b0;
   end

   // Head age: counts cycles a non-empty FIFO goes unserved.
   assign waiting    = !fifo_empty && !pop;
   assign starve_inc = starve_cnt + SW'(1);
   assign starve_hit = waiting && (starve_inc >= SW'(STARVE_LIMIT));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reg_write    <= 1'b0;
         rd           <= REG_ZERO;
         wd           <= '0;
         pending_mask <= '0;
         starve_cnt   <= '0;
         wb_stall     <= 1'b0;
         proto_err    <= 1'b0;
      end else begin
         reg_write <= alu_sel || pop;
         if (alu_sel) begin
            rd <= alu_rd;
            wd <= alu_data;
         end else if (pop) begin
            rd <= head.rd;
            wd <= head.data;
         end
         pending_mask <= pending_nxt;
         wb_stall     <= starve_hit;
         starve_cnt   <= (!waiting || starve_hit) ? '0 : starve_inc;
         if (alu_valid && wb_stall) proto_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: directed scenarios followed by random
// traffic, all checked every cycle against a queue-based reference model.
module tb_regfile_wb_arbiter;

   localparam int unsigned DEPTH  = 2;
   localparam int unsigned STARVE = 4;

   logic        clk;
   logic        rst_n;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        md_issue_valid;
   logic [4:0]  md_issue_rd;
   logic        md_valid;
   logic [4:0]  md_rd;
   logic [31:0] md_data;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic        hazard;
   logic        issue_conflict;
   logic        wb_stall;
   logic        reg_write;
   logic [4:0]  rd;
   logic [31:0] wd;
   logic [31:0] pending_mask;
   logic        proto_err;

   regfile_wb_arbiter_if md_bus ();
   assign md_bus.md_valid = md_valid;
   assign md_bus.md_rd    = md_rd;
   assign md_bus.md_data  = md_data;

   regfile_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .alu_valid      (alu_valid),
      .alu_rd         (alu_rd),
      .alu_data       (alu_data),
      .md_issue_valid (md_issue_valid),
      .md_issue_rd    (md_issue_rd),
      .md             (md_bus),
      .rs1            (rs1),
      .rs2            (rs2),
      .hazard         (hazard),
      .issue_conflict (issue_conflict),
      .wb_stall       (wb_stall),
      .reg_write      (reg_write),
      .rd             (rd),
      .wd             (wd),
      .pending_mask   (pending_mask),
      .proto_err      (proto_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Reference model state.
   logic [36:0] mq[$];
   logic [31:0] m_pend;
   int          m_wait;
   bit          m_stall;
   bit          m_proto;
   bit          m_rw;
   logic [4:0]  m_rd;
   logic [31:0] m_wd;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_pend  = '0;
      m_wait  = 0;
      m_stall = 0;
      m_proto = 0;
      m_rw    = 0;
      m_rd    = '0;
      m_wd    = '0;
   endtask

   // One clock of the arbitration rules, applied to the inputs now driven.
   task automatic model_step();
      int          sz;
      bit          popped;
      logic [36:0] e;
      sz     = mq.size();
      popped = 0;
      if (m_stall && alu_valid) m_proto = 1;
      if (alu_valid && alu_rd != 0) begin
         m_rw = 1; m_rd = alu_rd; m_wd = alu_data;
      end else if (sz > 0) begin
         e = mq.pop_front();
         m_rw = 1; m_rd = e[36:32]; m_wd = e[31:0];
         m_pend[m_rd] = 1'b0;
         popped = 1;
      end else begin
         m_rw = 0;
      end
      if (md_valid && sz < int'(DEPTH) && md_rd != 0) mq.push_back({md_rd, md_data});
      if (md_issue_valid && md_issue_rd != 0) m_pend[md_issue_rd] = 1'b1;
      if (sz > 0 && !popped) begin
         m_wait++;
         if (m_wait >= int'(STARVE)) begin
            m_stall = 1; m_wait = 0;
         end else begin
            m_stall = 0;
         end
      end else begin
         m_wait = 0; m_stall = 0;
      end
   endtask

   task automatic check_comb();
      bit hz;
      bit cf;
      hz = (rs1 != 0 && m_pend[rs1]) || (rs2 != 0 && m_pend[rs2]);
      cf = md_issue_valid && md_issue_rd != 0 && m_pend[md_issue_rd];
      chk("hazard", hazard, hz);
      chk("issue_conflict", issue_conflict, cf);
      chk("md_ready", md_bus.md_ready, mq.size() < int'(DEPTH));
   endtask

   task automatic check_regs();
      chk("reg_write", reg_write, m_rw);
      chk("rd", rd, m_rd);
      chk("wd", wd, m_wd);
      chk("pending_mask", pending_mask, m_pend);
      chk("wb_stall", wb_stall, m_stall);
      chk("proto_err", proto_err, m_proto);
   endtask

   // Inputs are driven just after a rising edge; this advances one cycle.
   task automatic cyc();
      #1;
      check_comb();
      model_step();
      @(posedge clk);
      #1;
      check_regs();
   endtask

   task automatic idle();
      alu_valid = 0; alu_rd = '0; alu_data = '0;
      md_issue_valid = 0; md_issue_rd = '0;
      md_valid = 0; md_rd = '0; md_data = '0;
      rs1 = '0; rs2 = '0;
   endtask

   // ALU busy every cycle while three results are offered; hold_alu keeps
   // alu_valid high through the stall slot.
   task automatic starve_scenario(input bit hold_alu, input logic [4:0] base);
      idle();
      alu_valid = 1; alu_rd = 5'd1; alu_data = 32'hA100_0000;
      md_valid = 1; md_rd = base; md_data = 32'hB000_0000 | 32'(base);
      cyc();
      md_rd = base + 5'd1; md_data = 32'hB000_0000 | 32'(base + 5'd1);
      alu_data = 32'hA100_0001;
      cyc();
      md_rd = base + 5'd2; md_data = 32'hB000_0000 | 32'(base + 5'd2);
      #1 chk("md_ready_full", md_bus.md_ready, 1'b0);
      for (int i = 0; i < 3; i++) begin
         alu_data = 32'hA100_0010 + 32'(i);
         cyc();
      end
      chk("wb_stall_pulse", wb_stall, 1'b1);
      if (hold_alu) begin
         alu_rd = 5'd2; alu_data = 32'hC0DE_0002;
         cyc();
         chk("stall_alu_rd", rd, 5'd2);
         chk("stall_alu_wd", wd, 32'hC0DE_0002);
         chk("proto_set", proto_err, 1'b1);
      end else begin
         alu_valid = 0;
         cyc();
         chk("stall_head_rd", rd, base);
         chk("stall_head_wd", wd, 32'hB000_0000 | 32'(base));
         chk("stall_one_cycle", wb_stall, 1'b0);
      end
      idle();
      for (int i = 0; i < 6; i++) cyc();
   endtask

   initial begin
      idle();
      rst_n = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_reg_write", reg_write, 1'b0);
      chk("rst_rd", rd, 5'd0);
      chk("rst_wd", wd, 32'd0);
      chk("rst_pending", pending_mask, 32'd0);
      chk("rst_md_ready", md_bus.md_ready, 1'b1);
      chk("rst_wb_stall", wb_stall, 1'b0);
      chk("rst_proto", proto_err, 1'b0);
      rst_n = 1;
      cyc();

      // Single ALU write: visible next cycle only.
      alu_valid = 1; alu_rd = 5'd3; alu_data = 32'h1234;
      cyc();
      chk("alu_we", reg_write, 1'b1);
      chk("alu_rd", rd, 5'd3);
      chk("alu_wd", wd, 32'h1234);
      idle();
      cyc();
      chk("alu_we_drop", reg_write, 1'b0);

      // Mul/div: issue, hazard, result two cycles after acceptance.
      md_issue_valid = 1; md_issue_rd = 5'd5;
      cyc();
      idle();
      md_valid = 1; md_rd = 5'd5; md_data = 32'hDEADBEEF; rs1 = 5'd5;
      #1 chk("md_hazard", hazard, 1'b1);
      cyc();
      chk("md_no_early_write", reg_write, 1'b0);
      md_valid = 0;
      cyc();
      chk("md_we", reg_write, 1'b1);
      chk("md_rd", rd, 5'd5);
      chk("md_wd", wd, 32'hDEADBEEF);
      chk("md_pend_clear", pending_mask[5], 1'b0);
      #1 chk("md_hazard_clear", hazard, 1'b0);
      idle();
      cyc();

      starve_scenario(1'b0, 5'd10);

      // rd==0 traffic is inert; a queued entry drains under alu_rd==0.
      alu_valid = 1; alu_rd = 5'd0; alu_data = 32'hFF;
      md_valid = 1; md_rd = 5'd0; md_data = 32'hEE;
      cyc();
      chk("zero_no_write", reg_write, 1'b0);
      idle();
      cyc();
      chk("zero_not_pushed", reg_write, 1'b0);
      chk("zero_pending", pending_mask, 32'd0);
      alu_valid = 1; alu_rd = 5'd1; alu_data = 32'h11;
      md_valid = 1; md_rd = 5'd9; md_data = 32'h99;
      cyc();
      alu_rd = 5'd0; md_valid = 0;
      cyc();
      chk("zero_drain_rd", rd, 5'd9);
      chk("zero_drain_wd", wd, 32'h99);
      idle();
      cyc();

      // Re-issue of rd 7 in the cycle its earlier result pops.
      md_issue_valid = 1; md_issue_rd = 5'd7;
      cyc();
      idle();
      md_valid = 1; md_rd = 5'd7; md_data = 32'h77;
      cyc();
      md_valid = 0; md_issue_valid = 1; md_issue_rd = 5'd7;
      #1 chk("conflict_flag", issue_conflict, 1'b1);
      cyc();
      chk("conflict_pop_rd", rd, 5'd7);
      chk("conflict_pend_kept", pending_mask[7], 1'b1);
      idle();
      cyc();

      starve_scenario(1'b1, 5'd13);
      chk("proto_sticky", proto_err, 1'b1);

      // Asynchronous reset with entries queued and a pending bit set.
      alu_valid = 1; alu_rd = 5'd1; alu_data = 32'h5;
      md_valid = 1; md_rd = 5'd20; md_data = 32'h20;
      md_issue_valid = 1; md_issue_rd = 5'd20;
      cyc();
      md_rd = 5'd21; md_data = 32'h21; md_issue_valid = 0;
      cyc();
      idle();
      #2 rst_n = 0;
      model_reset();
      #1;
      chk("mid_rst_we", reg_write, 1'b0);
      chk("mid_rst_ready", md_bus.md_ready, 1'b1);
      chk("mid_rst_pending", pending_mask, 32'd0);
      chk("mid_rst_proto", proto_err, 1'b0);
      @(posedge clk);
      #1 rst_n = 1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("mid_rst_no_write", reg_write, 1'b0);
      end

      // Random traffic; the core mostly honours wb_stall.
      for (int i = 0; i < 400; i++) begin
         alu_valid = m_stall ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1);
         alu_rd = 5'($urandom_range(0, 7));
         alu_data = $urandom();
         md_issue_valid = ($urandom_range(0, 3) == 0);
         md_issue_rd = 5'($urandom_range(0, 7));
         md_valid = ($urandom_range(0, 1) == 1);
         md_rd = 5'($urandom_range(0, 7));
         md_data = $urandom();
         rs1 = 5'($urandom_range(0, 7));
         rs2 = 5'($urandom_range(0, 7));
         cyc();
      end
      idle();
      for (int i = 0; i < 8; i++) cyc();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
